// File: rtl/ecc_arb_pkg.sv
// ecc_arb_pkg: shared command/state types and widths for the ECC engine arbiter
package ecc_arb_pkg;
  localparam int ECC_ARB_CMD_W = 2;
  typedef enum logic [ECC_ARB_CMD_W-1:0] {
    CMD_NONE   = 2'b00,
    CMD_KEYGEN = 2'b01,
    CMD_SIGN   = 2'b10,
    CMD_VERIFY = 2'b11
  } ecc_arb_cmd_e;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } ecc_arb_state_e;
endpackage

// File: rtl/ecc_rr_picker.sv
// ecc_rr_picker: combinational rotate-priority pick of the first request at/after ptr
//   req    in  NUM_REQ   request vector
//   ptr    in  IW        round-robin start position
//   onehot out NUM_REQ   selected requester
//   idx    out IW        index of selected requester
//   any    out 1         at least one request present
module ecc_rr_picker import ecc_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);
  assign any = |req;
  // First pass finds the lowest set request (the wrap-around winner); the second
  // pass overrides it with the lowest set request at or above ptr, if one exists.
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = IW'(j);
      end
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (req[j] && IW'(j) >= ptr) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = IW'(j);
      end
  end
endmodule

// File: rtl/ecc_engine_arb.sv
// ecc_engine_arb: round-robin arbiter sharing one ECC engine between NUM_REQ requesters
//   clk, reset (async, active-high)
//   req_i/cmd_i      per-requester request level and 2-bit command
//   gnt_o            one-hot grant, held until release
//   done_o/err_o     1-cycle completion / error pulse to the owner
//   zeroize_i        abort everything, pulses eng_zeroize_o
//   eng_ready_i/eng_valid_i   engine idle / result valid
//   eng_start_o/eng_cmd_o     1-cycle command strobe and command
//   eng_zeroize_o    1-cycle engine zeroize strobe
//   Optional watchdog in WAIT_DONE: define ECC_ARB_TIMEOUT_EN.
module ecc_engine_arb import ecc_arb_pkg::*; #(
  parameter int          NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ*ECC_ARB_CMD_W-1:0]  cmd_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [NUM_REQ-1:0]                err_o,
  input  logic                              zeroize_i,
  input  logic                              eng_ready_i,
  input  logic                              eng_valid_i,
  output logic                              eng_start_o,
  output logic [ECC_ARB_CMD_W-1:0]          eng_cmd_o,
  output logic                              eng_zeroize_o
);
  localparam int IW = $clog2(NUM_REQ);
  ecc_arb_state_e state, state_d;
  ecc_arb_cmd_e cmd_q, cmd_d, pick_cmd;
  logic [NUM_REQ-1:0] gnt_d, done_d, err_d, pick_oh, own_oh;
  logic [IW-1:0] owner, owner_d, rr_ptr, rr_d, pick_idx;
  logic pick_any, start_d, zer_d, expired;
  ecc_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_i),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  assign own_oh = NUM_REQ'(1) << owner;
  assign eng_cmd_o = eng_start_o ? cmd_q : CMD_NONE;
  always_comb begin
    pick_cmd = CMD_NONE;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_oh[i]) pick_cmd = ecc_arb_cmd_e'(cmd_i[i*ECC_ARB_CMD_W +: ECC_ARB_CMD_W]);
  end
`ifdef ECC_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  // Counter sits at zero outside WAIT_DONE, so it is cleared on every entry.
  always_ff @(posedge clk or posedge reset)
    if (reset) wd_cnt <= '0;
    else wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 32'd1 : '0;
  assign expired = (state == WAIT_DONE) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state;
    gnt_d = gnt_o;
    owner_d = owner;
    cmd_d = cmd_q;
    rr_d = rr_ptr;
    start_d = 1'b0;
    done_d = '0;
    err_d = '0;
    zer_d = 1'b0;
    if (zeroize_i) begin
      state_d = IDLE;
      gnt_d = '0;
      zer_d = 1'b1;
    end else begin
      case (state)
        IDLE: if (pick_any && eng_ready_i) begin
          state_d = ISSUE;
          gnt_d = pick_oh;
          owner_d = pick_idx;
          cmd_d = pick_cmd;
        end
        ISSUE: if (cmd_q == CMD_NONE) begin
          done_d = own_oh;
          err_d = own_oh;
          state_d = RELEASE;
        end else begin
          start_d = 1'b1;
          state_d = WAIT_DONE;
        end
        // A real result in the expiry cycle takes precedence over the watchdog.
        WAIT_DONE: if (eng_valid_i && eng_ready_i) begin
          done_d = own_oh;
          state_d = RELEASE;
        end else if (expired) begin
          done_d = own_oh;
          err_d = own_oh;
          zer_d = 1'b1;
          state_d = RELEASE;
        end
        RELEASE: begin
          gnt_d = '0;
          rr_d = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      gnt_o <= '0;
      done_o <= '0;
      err_o <= '0;
      eng_start_o <= 1'b0;
      eng_zeroize_o <= 1'b0;
      owner <= '0;
      cmd_q <= CMD_NONE;
      rr_ptr <= '0;
    end else begin
      state <= state_d;
      gnt_o <= gnt_d;
      done_o <= done_d;
      err_o <= err_d;
      eng_start_o <= start_d;
      eng_zeroize_o <= zer_d;
      owner <= owner_d;
      cmd_q <= cmd_d;
      rr_ptr <= rr_d;
    end
endmodule

// File: tb/tb_ecc_engine_arb.sv
// tb_ecc_engine_arb: scoreboard bench for ecc_engine_arb (3 requesters, watchdog limit 16)
module tb_ecc_engine_arb;
  import ecc_arb_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] req_i = '0;
  logic [5:0] cmd_i = '0;
  logic zeroize_i = 1'b0, eng_ready_i = 1'b0, eng_valid_i = 1'b0;
  logic [2:0] gnt_o, done_o, err_o;
  logic eng_start_o, eng_zeroize_o;
  logic [1:0] eng_cmd_o;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [2:0] d; logic [2:0] e;} exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  ecc_engine_arb #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .cmd_i(cmd_i), .gnt_o(gnt_o),
    .done_o(done_o), .err_o(err_o), .zeroize_i(zeroize_i), .eng_ready_i(eng_ready_i),
    .eng_valid_i(eng_valid_i), .eng_start_o(eng_start_o), .eng_cmd_o(eng_cmd_o),
    .eng_zeroize_o(eng_zeroize_o)
  );
  always @(negedge clk)
    if (!reset) begin
      n_cmp++;
      if (!$onehot0(gnt_o) || (done_o & ~gnt_o) != 3'b0 || (err_o & ~done_o) != 3'b0) begin
        n_bad++;
        $display("FAIL invariant: gnt=%b done=%b err=%b", gnt_o, done_o, err_o);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_gnt(output logic [2:0] g);
    g = '0;
    for (int i = 0; i < 40; i++) begin
      if (gnt_o != 3'b0) begin
        g = gnt_o;
        break;
      end
      tick();
    end
  endtask
  task automatic wait_start(output bit seen, output logic [1:0] c);
    seen = 1'b0;
    c = '0;
    for (int i = 0; i < 40; i++) begin
      if (eng_start_o) begin
        seen = 1'b1;
        c = eng_cmd_o;
        break;
      end
      tick();
    end
  endtask
  task automatic respond(input int lat);
    repeat (lat) tick();
    eng_valid_i = 1'b1;
    tick();
    eng_valid_i = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({gnt_o, done_o, err_o, eng_start_o, eng_cmd_o, eng_zeroize_o} !== 14'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want all zero",
               {gnt_o, done_o, err_o, eng_start_o, eng_cmd_o, eng_zeroize_o});
    end
    reset = 1'b0;
    eng_ready_i = 1'b1;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_no_req: gnt=%b want 000", gnt_o);
    end
  endtask
  task automatic test_single();
    exp_t x;
    cmd_i = {CMD_NONE, CMD_NONE, CMD_SIGN};
    req_i = 3'b001;
    exp_q.push_back({3'b001, 3'b000});
    tick();
    n_cmp++;
    if (gnt_o !== 3'b001) begin n_bad++; $display("FAIL t1_gnt: gnt=%b want 001", gnt_o); end
    tick();
    n_cmp++;
    if ({eng_start_o, eng_cmd_o} !== 3'b110) begin
      n_bad++;
      $display("FAIL t1_start: start=%b cmd=%b want 1/10", eng_start_o, eng_cmd_o);
    end
    tick();
    n_cmp++;
    if (eng_start_o !== 1'b0) begin n_bad++; $display("FAIL t1_start_once: start=%b want 0", eng_start_o); end
    repeat (4) tick();
    eng_valid_i = 1'b1;
    tick();
    eng_valid_i = 1'b0;
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t1_done: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b000;
    tick();
    n_cmp++;
    if ({gnt_o, done_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL t1_release: gnt=%b done=%b want 000/000", gnt_o, done_o);
    end
  endtask
  task automatic test_round_robin();
    logic [2:0] order [4];
    logic [2:0] g;
    logic [1:0] c;
    bit seen;
    exp_t x;
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_i = {CMD_VERIFY, CMD_SIGN, CMD_KEYGEN};
    req_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      n_cmp++;
      if (g !== order[k]) begin n_bad++; $display("FAIL t2_gnt%0d: gnt=%b want %b", k, g, order[k]); end
      exp_q.push_back({order[k], 3'b000});
      wait_start(seen, c);
      n_cmp++;
      if ({seen, c} !== {1'b1, 2'(k % 3 + 1)}) begin
        n_bad++;
        $display("FAIL t2_cmd%0d: seen=%b cmd=%b want 1/%b", k, seen, c, 2'(k % 3 + 1));
      end
      respond(1);
      x = exp_q.pop_front();
      n_cmp++;
      if ({done_o, err_o} !== {x.d, x.e}) begin
        n_bad++;
        $display("FAIL t2_done%0d: done=%b err=%b want %b/%b", k, done_o, err_o, x.d, x.e);
      end
      if (k == 3) req_i = 3'b000;
      tick();
      n_cmp++;
      if (gnt_o !== 3'b000) begin n_bad++; $display("FAIL t2_gap%0d: gnt=%b want 000", k, gnt_o); end
    end
  endtask
  task automatic test_none_cmd();
    logic [2:0] g;
    logic [1:0] c;
    bit seen;
    exp_t x;
    cmd_i = {CMD_VERIFY, CMD_NONE, CMD_KEYGEN};
    req_i = 3'b010;
    exp_q.push_back({3'b010, 3'b010});
    wait_gnt(g);
    n_cmp++;
    if (g !== 3'b010) begin n_bad++; $display("FAIL t3_gnt: gnt=%b want 010", g); end
    tick();
    n_cmp++;
    if (eng_start_o !== 1'b0) begin n_bad++; $display("FAIL t3_no_start: start=%b want 0", eng_start_o); end
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t3_done_err: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b111;
    cmd_i = {CMD_VERIFY, CMD_SIGN, CMD_KEYGEN};
    tick();
    wait_gnt(g);
    n_cmp++;
    if (g !== 3'b100) begin n_bad++; $display("FAIL t3_rr_advance: gnt=%b want 100", g); end
    exp_q.push_back({3'b100, 3'b000});
    wait_start(seen, c);
    n_cmp++;
    if ({seen, c} !== 3'b111) begin n_bad++; $display("FAIL t3_cmd: seen=%b cmd=%b want 1/11", seen, c); end
    respond(0);
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t3_done2: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b000;
    tick();
  endtask
  task automatic test_zeroize();
    logic [2:0] g;
    logic [1:0] c;
    bit seen;
    exp_t x;
    req_i = 3'b001;
    wait_gnt(g);
    n_cmp++;
    if (g !== 3'b001) begin n_bad++; $display("FAIL t4_gnt: gnt=%b want 001", g); end
    wait_start(seen, c);
    repeat (2) tick();
    zeroize_i = 1'b1;
    tick();
    zeroize_i = 1'b0;
    n_cmp++;
    if ({eng_zeroize_o, gnt_o, done_o, err_o} !== 10'b1_000_000_000) begin
      n_bad++;
      $display("FAIL t4_abort: zer=%b gnt=%b done=%b err=%b want 1/000/000/000",
               eng_zeroize_o, gnt_o, done_o, err_o);
    end
    req_i = 3'b011;
    tick();
    n_cmp++;
    if ({eng_zeroize_o, gnt_o, done_o} !== 7'b0_001_000) begin
      n_bad++;
      $display("FAIL t4_same_rr: zer=%b gnt=%b done=%b want 0/001/000", eng_zeroize_o, gnt_o, done_o);
    end
    exp_q.push_back({3'b001, 3'b000});
    wait_start(seen, c);
    respond(0);
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t4_done: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b000;
    tick();
  endtask
  task automatic test_timeout();
    logic [2:0] g;
    logic [1:0] c;
    bit seen;
    req_i = 3'b010;
    wait_gnt(g);
    n_cmp++;
    if (g !== 3'b010) begin n_bad++; $display("FAIL t5_gnt: gnt=%b want 010", g); end
`ifdef ECC_ARB_TIMEOUT_EN
    begin
      exp_t x;
      int n;
      exp_q.push_back({3'b010, 3'b010});
      wait_start(seen, c);
      n = 0;
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (done_o != 3'b000) begin
          n = i;
          break;
        end
      end
      n_cmp++;
      if (n != 16) begin n_bad++; $display("FAIL t5_expiry: cycles=%0d want 16", n); end
      n_cmp++;
      if (eng_zeroize_o !== 1'b1) begin n_bad++; $display("FAIL t5_zeroize: zer=%b want 1", eng_zeroize_o); end
      x = exp_q.pop_front();
      n_cmp++;
      if ({done_o, err_o} !== {x.d, x.e}) begin
        n_bad++;
        $display("FAIL t5_done_err: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
      end
      req_i = 3'b000;
      tick();
    end
`else
    begin
      bit held;
      wait_start(seen, c);
      held = 1'b1;
      repeat (1000) begin
        tick();
        if (gnt_o !== 3'b010 || done_o !== 3'b000) held = 1'b0;
      end
      n_cmp++;
      if (!held) begin n_bad++; $display("FAIL t5_hold: grant held=%b want 1", held); end
      zeroize_i = 1'b1;
      tick();
      zeroize_i = 1'b0;
      req_i = 3'b000;
      n_cmp++;
      if ({eng_zeroize_o, gnt_o} !== 4'b1_000) begin
        n_bad++;
        $display("FAIL t5_abort: zer=%b gnt=%b want 1/000", eng_zeroize_o, gnt_o);
      end
      tick();
    end
`endif
  endtask
  task automatic test_ready_low();
    logic [1:0] c;
    bit seen, stuck;
    exp_t x;
    eng_ready_i = 1'b0;
    req_i = 3'b010;
    stuck = 1'b0;
    repeat (5) begin
      tick();
      if (gnt_o != 3'b000) stuck = 1'b1;
    end
    n_cmp++;
    if (stuck) begin n_bad++; $display("FAIL t6_no_grant: granted=%b want 0", stuck); end
    eng_ready_i = 1'b1;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b010) begin n_bad++; $display("FAIL t6_gnt: gnt=%b want 010", gnt_o); end
    exp_q.push_back({3'b010, 3'b000});
    wait_start(seen, c);
    respond(0);
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t6_done: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b000;
    tick();
  endtask
  task automatic test_reset_mid();
    logic [2:0] g;
    logic [1:0] c;
    bit seen;
    exp_t x;
    req_i = 3'b100;
    wait_gnt(g);
    wait_start(seen, c);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({gnt_o, eng_start_o, done_o, eng_zeroize_o} !== 8'b0) begin
      n_bad++;
      $display("FAIL t7_async_reset: gnt=%b start=%b done=%b zer=%b want zeros",
               gnt_o, eng_start_o, done_o, eng_zeroize_o);
    end
    tick();
    reset = 1'b0;
    req_i = 3'b111;
    wait_gnt(g);
    n_cmp++;
    if (g !== 3'b001) begin n_bad++; $display("FAIL t7_rr_reset: gnt=%b want 001", g); end
    exp_q.push_back({3'b001, 3'b000});
    wait_start(seen, c);
    respond(0);
    x = exp_q.pop_front();
    n_cmp++;
    if ({done_o, err_o} !== {x.d, x.e}) begin
      n_bad++;
      $display("FAIL t7_done: done=%b err=%b want %b/%b", done_o, err_o, x.d, x.e);
    end
    req_i = 3'b000;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_none_cmd();
    test_zeroize();
    test_timeout();
    test_ready_low();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_empty: left=%0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
